// File: rtl/bp_pkg.sv
// ============================================================================
// Module : bp_pkg
// Brief  : Shared BTB types, counter-state constants and PC field helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    // The entry struct is sized by these; branch_predictor defaults to them.
    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = 8;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        logic [1:0]          ctr;
    } btb_entry_t;

    function automatic logic [BP_XLEN-1:0] pc_index(input logic [BP_XLEN-1:0] pc,
                                                    input int idx_w);
        return (pc >> 2) & ((BP_XLEN'(1) << idx_w) - BP_XLEN'(1));
    endfunction

    function automatic logic [BP_TAG_W-1:0] pc_tag(input logic [BP_XLEN-1:0] pc,
                                                   input int idx_w);
        return BP_TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module : sat_counter2
// Brief  : Next-state logic of a 2-bit saturating up/down counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module : branch_predictor
// Brief  : Direct-mapped BTB with 2-bit counters, F->D->E prediction pipe,
//          Execute-stage training, misprediction detect and perf counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = BP_TAG_W,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [XLEN-1:0]  PCE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [XLEN-1:0]  TargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t r_btb [ENTRIES];

    logic             r_pred_taken_d;
    logic [XLEN-1:0]  r_pred_target_d;
    logic             r_pred_taken_e;
    logic [XLEN-1:0]  r_pred_target_e;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_f;
    logic [TAG_W-1:0] w_tag_e;
    btb_entry_t       w_ent_f;
    btb_entry_t       w_ent_e;
    logic             w_hit_f;
    logic             w_hit_e;
    logic [1:0]       w_ctr_next;

    // Fetch lookup (asynchronous read; sees pre-update table state)
    assign w_idx_f     = IDX_W'(pc_index(PCF, IDX_W));
    assign w_tag_f     = pc_tag(PCF, IDX_W);
    assign w_ent_f     = r_btb[w_idx_f];
    assign w_hit_f     = w_ent_f.valid && (w_ent_f.tag == w_tag_f);
    assign PredTakenF  = w_hit_f && w_ent_f.ctr[1];
    assign PredTargetF = PredTakenF ? w_ent_f.target : PCF + XLEN'(4);

    // Execute-side view of the entry being trained
    assign w_idx_e = IDX_W'(pc_index(PCE, IDX_W));
    assign w_tag_e = pc_tag(PCE, IDX_W);
    assign w_ent_e = r_btb[w_idx_e];
    assign w_hit_e = w_ent_e.valid && (w_ent_e.tag == w_tag_e);

    sat_counter2 u_sat_counter2 (
        .i_ctr (w_ent_e.ctr),
        .i_inc (TakenE),
        .o_ctr (w_ctr_next)
    );

    // A predicted-taken non-branch means the entry aliased a different instruction
    assign MispredictE = BranchE
                       ? ((TakenE != r_pred_taken_e) ||
                          (TakenE && (TargetE != r_pred_target_e)))
                       : r_pred_taken_e;
    assign RedirectPCE = TakenE ? TargetE : PCE + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].ctr   <= WNT;
            end
        end else if (BranchE) begin
            if (w_hit_e) begin
                r_btb[w_idx_e].ctr <= w_ctr_next;
                if (TakenE) r_btb[w_idx_e].target <= TargetE;
            end else if (TakenE) begin
                r_btb[w_idx_e] <= '{valid: 1'b1, tag: w_tag_e, target: TargetE, ctr: WT};
            end
        end else if (w_hit_e && r_pred_taken_e) begin
            r_btb[w_idx_e].valid <= 1'b0;
        end
    end

    // Flush wins over stall in Decode
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (!StallD) begin
            r_pred_taken_d  <= PredTakenF;
            r_pred_target_d <= PredTargetF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_pred_taken_e  <= 1'b0;
            r_pred_target_e <= '0;
        end else begin
            r_pred_taken_e  <= r_pred_taken_d;
            r_pred_target_e <= r_pred_target_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (BranchE && (r_branch_cnt != {CNT_W{1'b1}}))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (MispredictE && (r_mispred_cnt != {CNT_W{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module : tb_branch_predictor
// Brief  : Directed + random checks of branch_predictor against a table model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        StallD, FlushD, FlushE;
    logic [31:0] PCE;
    logic        BranchE, TakenE;
    logic [31:0] TargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [3:0]  BranchCount, MispredictCount;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .PCF             (PCF),
        .PredTakenF      (PredTakenF),
        .PredTargetF     (PredTargetF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .PCE             (PCE),
        .BranchE         (BranchE),
        .TakenE          (TakenE),
        .TargetE         (TargetE),
        .MispredictE     (MispredictE),
        .RedirectPCE     (RedirectPCE),
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
    );

    always #5 clk = ~clk;

    // Reference model: per-index table plus the two prediction stages
    bit          mv  [16];
    int          mt  [16];
    int          mc  [16];
    logic [31:0] mtg [16];
    bit          pd_t, pe_t;
    logic [31:0] pd_g, pe_g;
    int          bc, mcnt;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void lookup(input logic [31:0] pc, output bit hit,
                                   output bit pt, output logic [31:0] tgt);
        int idx;
        idx = int'(pc[5:2]);
        hit = mv[idx] && (mt[idx] == int'(pc[13:6]));
        pt  = hit && (mc[idx] >= 2);
        tgt = pt ? mtg[idx] : pc + 32'd4;
    endfunction

    task automatic cycle();
        bit          hf, ptf, he, pte, mis;
        logic [31:0] tgf, tge;
        int          ie;
        @(negedge clk);
        lookup(PCF, hf, ptf, tgf);
        if (BranchE) mis = (TakenE != pe_t) || (TakenE && (TargetE != pe_g));
        else         mis = pe_t;
        if (chk_en) begin
            check("PredTakenF", 32'(PredTakenF), 32'(ptf));
            check("PredTargetF", PredTargetF, tgf);
            check("MispredictE", 32'(MispredictE), 32'(mis));
            check("RedirectPCE", RedirectPCE, TakenE ? TargetE : PCE + 32'd4);
            check("BranchCount", 32'(BranchCount), 32'(bc));
            check("MispredictCount", 32'(MispredictCount), 32'(mcnt));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mv[i] = 1'b0;
                mc[i] = 1;
            end
            pd_t = 1'b0; pd_g = '0; pe_t = 1'b0; pe_g = '0;
            bc = 0; mcnt = 0;
        end else begin
            lookup(PCE, he, pte, tge);
            ie = int'(PCE[5:2]);
            if (BranchE) begin
                if (he) begin
                    mc[ie] = TakenE ? ((mc[ie] < 3) ? mc[ie] + 1 : 3)
                                    : ((mc[ie] > 0) ? mc[ie] - 1 : 0);
                    if (TakenE) mtg[ie] = TargetE;
                end else if (TakenE) begin
                    mv[ie] = 1'b1; mt[ie] = int'(PCE[13:6]); mtg[ie] = TargetE; mc[ie] = 2;
                end
                if (bc < CNT_MAX) bc++;
            end else if (he && pe_t) begin
                mv[ie] = 1'b0;
            end
            if (mis && mcnt < CNT_MAX) mcnt++;
            if (FlushE) begin pe_t = 1'b0; pe_g = '0; end
            else        begin pe_t = pd_t; pe_g = pd_g; end
            if (FlushD)       begin pd_t = 1'b0; pd_g = '0; end
            else if (!StallD) begin pd_t = ptf;  pd_g = tgf; end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] pcf, input logic br, input logic tk,
                         input logic [31:0] pce, input logic [31:0] tge,
                         input logic st, input logic fd, input logic fe);
        PCF = pcf; BranchE = br; TakenE = tk; PCE = pce; TargetE = tge;
        StallD = st; FlushD = fd; FlushE = fe;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mc[i] = 1; mt[i] = 0; mtg[i] = '0; end
        pd_t = 1'b0; pd_g = '0; pe_t = 1'b0; pe_g = '0; bc = 0; mcnt = 0;

        // Reset for two cycles
        reset = 1'b1;
        drive(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("rst_pred_taken", 32'(PredTakenF), 32'h0);
        check("rst_pred_target", PredTargetF, 32'h104);
        check("rst_counts", {BranchCount, MispredictCount}, 32'h0);

        // Allocate 0x40 -> 0x80, then predict it
        drive(32'h100, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
        check("alloc_mispredict", 32'(MispredictE), 32'h1);
        check("alloc_redirect", RedirectPCE, 32'h80);
        cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("alloc_pred_taken", 32'(PredTakenF), 32'h1);
        check("alloc_pred_target", PredTargetF, 32'h80);
        cycle();

        // Hysteresis: WT -> WNT -> WT -> ST -> WT
        drive(32'h100, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("hyst_wnt_not_taken", 32'(PredTakenF), 32'h0);
        cycle();
        for (int k = 0; k < 2; k++) begin
            drive(32'h100, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        drive(32'h100, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("hyst_st_still_taken", 32'(PredTakenF), 32'h1);
        cycle();

        // Alias: taken prediction carried to E for a non-branch at 0x40
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(32'h100, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(32'h100, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        check("alias_mispredict", 32'(MispredictE), 32'h1);
        check("alias_redirect", RedirectPCE, 32'h44);
        cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("alias_invalidated", 32'(PredTakenF), 32'h0);
        cycle();

        // Stall + flush on D: flush wins, E then sees an empty prediction
        drive(32'h100, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(32'h100, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(32'h100, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
        check("flush_e_got_taken", 32'(MispredictE), 32'h0);
        cycle();
        drive(32'h100, 1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
        check("flush_d_cleared", 32'(MispredictE), 32'h1);
        cycle();

        // Counter saturation and mid-run reset
        for (int k = 0; k < 20; k++) begin
            drive(32'h200, 1'b1, 1'b1, 32'h300, 32'h500, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        check("sat_branch_count", 32'(BranchCount), 32'd15);
        check("sat_mispred_count", 32'(MispredictCount), 32'd15);
        reset = 1'b1;
        drive(32'h200, 1'b1, 1'b1, 32'h300, 32'h500, 1'b0, 1'b0, 1'b0);
        cycle();
        reset = 1'b0;
        #1;
        check("midrst_branch_count", 32'(BranchCount), 32'd0);
        check("midrst_mispred_count", 32'(MispredictCount), 32'd0);

        // Randomized traffic over a small PC set to force hits and aliases
        for (int k = 0; k < 400; k++) begin
            logic [31:0] pf, pe, te;
            pf = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2);
            pe = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2);
            te = 32'($urandom) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) te = 32'hFFFF_FFFC;
            reset = ($urandom_range(0, 63) == 0);
            drive(pf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pe, te,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0));
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the 5-stage RV32 pipeline: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters per entry. It generalises the current single PC-select mux, which resolves every branch in Execute and always fetches PC+4. The block predicts next-PC in Fetch and carries each prediction through the Decode and Execute stages. When the branch resolves in Execute it trains the table, flags mispredictions and supplies the redirect PC.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- TAG_W, 8, stored tag bits; requires 2+IDX_W+TAG_W ≤ XLEN
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCF  in  XLEN  fetch PC
- PredTakenF  out  1  predict taken in Fetch
- PredTargetF  out  XLEN  predicted next PC (stored target if taken, else PCF+4)
- StallD  in  1  hold the Decode prediction register
- FlushD  in  1  clear the Decode prediction register
- FlushE  in  1  clear the Execute prediction register
- PCE  in  XLEN  PC of the instruction in Execute
- BranchE  in  1  instruction in Execute is a branch/jal/jalr
- TakenE  in  1  resolved outcome (always 1 for jumps)
- TargetE  in  XLEN  resolved target
- MispredictE  out  1  redirect required this cycle
- RedirectPCE  out  XLEN  TakenE ? TargetE : PCE+4
- BranchCount  out  CNT_W  number of resolved branches, saturating
- MispredictCount  out  CNT_W  number of mispredictions, saturating

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds {valid, tag, target[XLEN], ctr[1:0]}. Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Fetch lookup is combinational:
  - hit = valid & tag match on PCF.
  - PredTakenF = hit & ctr[1].
- Prediction pipeline: {PredTaken, PredTarget} is registered F→D→E.
  - FlushD/FlushE clear the respective stage to {0, 0}.
  - StallD holds the D stage.
  - Flush has priority over stall.
- MispredictE:
  - When BranchE=1: asserted if TakenE≠PredTakenE, or if TakenE & (TargetE≠PredTargetE).
  - When BranchE=0: asserted if PredTakenE=1 (alias).
- Training is applied at the clock edge, using PCE's index and tag:
  - BranchE & hit: ctr increments on TakenE and decrements otherwise, saturating at ST/SNT. If TakenE, target ← TargetE.
  - BranchE & miss & TakenE: allocate the entry as {1, tag, TargetE, WT}, overwriting the previous occupant.
  - BranchE & miss & !TakenE: no change.
  - !BranchE & hit & PredTakenE: invalidate the entry (valid ← 0).
- Performance counters, both saturating at all-ones:
  - BranchCount += BranchE.
  - MispredictCount += MispredictE.
- Width rules: all PC arithmetic is modulo 2^XLEN; PC+4 wraps silently.

## Timing
- Prediction latency: 0 cycles. PredTakenF and PredTargetF are combinational from PCF and table state.
- Training latency: 1 cycle. An update in cycle n is visible to lookups in cycle n+1.
- Same-index read and write in one cycle: the lookup sees pre-update state (read-before-write).
- MispredictE and RedirectPCE are combinational in Execute. The hazard unit uses MispredictE the same cycle to assert FlushD/FlushE.
- Reset (synchronous, including mid-operation), applied at the next edge:
  - all valid bits ← 0, all ctr ← WNT;
  - D and E prediction registers ← 0;
  - both performance counters ← 0.
- Output values after reset:
  - PredTakenF = 0 and PredTargetF = PCF+4;
  - MispredictE = 0 unless BranchE & TakenE.
- While reset is asserted, training and counting are suppressed.

## Structure
- Shared package bp_pkg holds:
  - the counter-state constants SNT/WNT/WT/ST;
  - the btb_entry_t struct, parametrised via localparam widths;
  - the index/tag extraction functions.
- One sub-module: sat_counter2, a 2-bit saturating up/down counter with next-state logic. It is instantiated per entry or used as a function in the update path.
- The table is an array of btb_entry_t registers, not RAM macros, because the lookup is asynchronous.

## Test plan
- **Reset:** assert reset for 2 cycles with PCF=0x100 → PredTakenF=0, PredTargetF=0x104, both counters 0.
- **Allocate then predict:** present BranchE=1, TakenE=1, PCE=0x40, TargetE=0x80 at a miss.
  - MispredictE=1 and RedirectPCE=0x80.
  - Next cycle, PCF=0x40 gives PredTakenF=1 and PredTargetF=0x80.
- **Counter hysteresis:** with the entry at WT, apply not-taken at 0x40 (→WNT).
  - PCF=0x40 now predicts not-taken.
  - Two takens then give ST; one not-taken still predicts taken.
- **Alias:** use ENTRIES=16 and the allocated entry at 0x40.
  - A non-branch at PCE=0x40 with PredTakenE=1 gives MispredictE=1 and RedirectPCE=0x44.
  - The entry is invalidated; the next lookup gives PredTakenF=0.
- **Stall/flush priority:** StallD=1 & FlushD=1 with D holding a taken prediction → D cleared; E receives {0, 0} next cycle.
- **Counter saturation:** with CNT_W=4, apply 20 mispredicted branches → BranchCount = MispredictCount = 15. A mid-run reset returns both to 0 at the next edge.
